// File: rtl/vert_mac_col_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vert_mac_col_scheduler
// Description : Sequences one bit-serial vertical MAC tile. Walks the weight
//               bit-columns MSB->LSB and skips columns that the mask marks as
//               empty. Drives column_idx/is_msb/en_acc/load_accum into the MAC
//               array. A single drain cycle flushes the MAC's two-stage
//               (psum -> accum) pipeline. Issue stalls while the column
//               operands are missing (col_valid low).
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start, col_mask - tile request; mask latched on accept
//               col_valid       - operands for column_idx present at the MAC
//               busy            - not idle
//               en_acc          - MAC enable
//               load_accum      - MAC reloads its accumulator from accum_prev
//               column_idx      - current column / metadata read index
//               is_msb          - issuing column NUM_COL-1
//               col_ack         - column consumed this cycle
//               done            - one-cycle pulse, MAC result is final
// Revision    : 1.0 - initial release
// ============================================================================
module vert_mac_col_scheduler #(
    parameter int NUM_COL = 8,
    parameter int COL_W   = $clog2(NUM_COL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUM_COL-1:0] col_mask,
    input  logic               col_valid,
    output logic               busy,
    output logic               en_acc,
    output logic               load_accum,
    output logic [COL_W-1:0]   column_idx,
    output logic               is_msb,
    output logic               col_ack,
    output logic               done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [COL_W-1:0]   c_MSB_IDX  = COL_W'(NUM_COL - 1);
    localparam logic [NUM_COL-1:0] c_MSB_ONLY = {1'b1, {(NUM_COL-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NUM_COL-1:0] r_rem_mask;
    logic [NUM_COL-1:0] w_rem_mask_nxt;
    logic [1:0]         r_issue_cnt;
    logic [1:0]         w_issue_cnt_nxt;
    logic [1:0]         w_issue_cnt_inc;
    logic [COL_W-1:0]   w_hi_idx;
    logic [NUM_COL-1:0] w_hi_onehot;
    logic [NUM_COL-1:0] w_rem_after_ack;

    // Highest set bit of the remaining mask; the later (higher) index wins.
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            if (r_rem_mask[i]) begin
                w_hi_idx = COL_W'(i);
            end
        end
    end

    assign w_hi_onehot     = NUM_COL'(1) << w_hi_idx;
    assign w_rem_after_ack = r_rem_mask & ~w_hi_onehot;

    // The counter only has to tell the 1st, 2nd and later en_acc cycles apart.
    assign w_issue_cnt_inc = (r_issue_cnt == 2'd2) ? 2'd2 : r_issue_cnt + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_rem_mask  <= '0;
            r_issue_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem_mask  <= w_rem_mask_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_mask_nxt  = r_rem_mask;
        w_issue_cnt_nxt = r_issue_cnt;
        busy            = 1'b0;
        en_acc          = 1'b0;
        load_accum      = 1'b0;
        column_idx      = '0;
        is_msb          = 1'b0;
        col_ack         = 1'b0;
        done            = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_ISSUE;
                    // An empty mask still issues the MSB column, so the
                    // accumulator is always reloaded from accum_prev.
                    w_rem_mask_nxt  = (col_mask == '0) ? c_MSB_ONLY : col_mask;
                    w_issue_cnt_nxt = 2'd0;
                end
            end

            c_ST_ISSUE: begin
                busy       = 1'b1;
                column_idx = w_hi_idx;
                is_msb     = (w_hi_idx == c_MSB_IDX);
                // Without operands the whole MAC pipeline freezes, and the
                // column is held.
                if (col_valid) begin
                    en_acc          = 1'b1;
                    col_ack         = 1'b1;
                    load_accum      = (r_issue_cnt == 2'd1);
                    w_rem_mask_nxt  = w_rem_after_ack;
                    w_issue_cnt_nxt = w_issue_cnt_inc;
                    if (w_rem_after_ack == '0) begin
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
            end

            c_ST_DRAIN: begin
                // This cycle moves the last psum into accum. It becomes the
                // load cycle when the tile issued only a single column.
                busy            = 1'b1;
                en_acc          = 1'b1;
                load_accum      = (r_issue_cnt == 2'd1);
                w_issue_cnt_nxt = w_issue_cnt_inc;
                w_state_nxt     = c_ST_DONE;
            end

            c_ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
